// File: rtl/kf_pkg.sv
// Shared types and constants for the multi-channel scalar Kalman filter engine.
// The saturating helpers are only referenced when KF_SAT_EN is defined.
package kf_pkg;

  localparam int unsigned DefW    = 24;
  localparam int unsigned DefFrac = 14;
  localparam int unsigned DefOne  = 1 << DefFrac;

  // Reset context: x = 0, P = ONE, Q = 0, R = ONE
  localparam int signed RstX = 0;
  localparam int signed RstQ = 0;

  typedef enum logic [2:0] {
    StIdle,
    StPred,
    StDiv,
    StUpd,
    StOut
  } state_e;

  typedef enum logic [1:0] {
    CfgX = 2'b00,
    CfgP = 2'b01,
    CfgQ = 2'b10,
    CfgR = 2'b11
  } cfg_sel_e;

  // Clip a sign-extended value into the signed range of a w-bit word (w <= 32).
  function automatic logic signed [63:0] sat_clip(input logic signed [63:0] v,
                                                  input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int unsigned w);
    return sat_clip(a + b, w);
  endfunction

endpackage

// File: rtl/kf_div_seq.sv
// Sequential restoring divider: quot = (num << FRAC) / den, truncated to W bits.
// Retires two quotient bits per cycle so the full 2W-bit dividend fits in W cycles.
module kf_div_seq #(
  parameter int unsigned W    = 24,
  parameter int unsigned FRAC = 14
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic signed [W-1:0] num,
  input  logic signed [W-1:0] den,
  output logic                done,
  output logic        [W-1:0] quot,
  output logic                div0
);

  localparam int unsigned CntW = $clog2(W + 1);

  logic [2*W-1:0]  dvd_q;
  logic [W-1:0]    rem_q;
  logic [W-1:0]    rem_d;
  logic [W-1:0]    den_q;
  logic [W-1:0]    quot_q;
  logic [W-1:0]    quot_d;
  logic [CntW-1:0] cnt_q;
  logic            active_q;
  logic            done_q;
  logic            div0_q;
  logic            bad;
  logic [W:0]      r1;
  logic [W:0]      r2;
  logic            q1;
  logic            q2;

  assign bad = (den <= 0) || (num < 0);

  // Two restoring steps per cycle; the remainder always stays below den.
  always_comb begin
    r1 = {rem_q, dvd_q[2*W-1]};
    q1 = (r1 >= {1'b0, den_q});
    if (q1) r1 = r1 - {1'b0, den_q};
    r2 = {r1[W-1:0], dvd_q[2*W-2]};
    q2 = (r2 >= {1'b0, den_q});
    if (q2) r2 = r2 - {1'b0, den_q};
    rem_d  = r2[W-1:0];
    quot_d = {quot_q[W-3:0], q1, q2};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dvd_q    <= '0;
      rem_q    <= '0;
      den_q    <= '0;
      quot_q   <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      div0_q   <= 1'b0;
    end else if (start) begin
      div0_q   <= bad;
      dvd_q    <= bad ? '0 : ((2 * W)'(num) << FRAC);
      den_q    <= den;
      rem_q    <= '0;
      quot_q   <= '0;
      cnt_q    <= CntW'(W);
      active_q <= 1'b1;
      done_q   <= 1'b0;
    end else if (active_q) begin
      // A div0 sample still burns the full count to keep latency fixed.
      if (!div0_q) begin
        dvd_q  <= dvd_q << 2;
        rem_q  <= rem_d;
        quot_q <= quot_d;
      end
      cnt_q <= cnt_q - CntW'(1);
      if (cnt_q == CntW'(1)) begin
        active_q <= 1'b0;
        done_q   <= 1'b1;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  assign done = done_q;
  assign quot = quot_q;
  assign div0 = div0_q;

endmodule

// File: rtl/kf_scalar_mc.sv
// Time-multiplexed multi-channel scalar Kalman filter (predict + update per measurement).
// Define KF_SAT_EN to saturate Pp, S, e, the x update and product shifts instead of wrapping.
module kf_scalar_mc
  import kf_pkg::*;
#(
  parameter int unsigned W    = DefW,
  parameter int unsigned FRAC = DefFrac,
  parameter int unsigned NCH  = 4,
  localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [CHW-1:0] in_ch,
  input  logic [W-1:0]   in_z,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [CHW-1:0] out_ch,
  output logic [W-1:0]   out_x,
  output logic [W-1:0]   out_p,
  output logic           out_div0,
  input  logic           cfg_we,
  input  logic [1:0]     cfg_sel,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [W-1:0]   cfg_wdata,
  output logic           busy
);

  localparam logic signed [W-1:0] One = W'(1 << FRAC);

  state_e state_q, state_d;

  logic signed [W-1:0] x_q [NCH];
  logic signed [W-1:0] p_q [NCH];
  logic signed [W-1:0] q_q [NCH];
  logic signed [W-1:0] r_q [NCH];

  logic [CHW-1:0]      ch_q;
  logic signed [W-1:0] z_q;
  logic signed [W-1:0] pp_q;
  logic [CHW-1:0]      out_ch_q;
  logic [W-1:0]        out_x_q;
  logic [W-1:0]        out_p_q;
  logic                out_div0_q;

  logic                accept;
  logic                ch_ok;
  logic                cfg_hit;
  logic signed [W-1:0] x_cur;
  logic signed [W-1:0] pp_c;
  logic signed [W-1:0] s_c;
  logic signed [W-1:0] k_s;
  logic signed [W-1:0] e_c;
  logic signed [2*W-1:0] kxe_c;
  logic signed [2*W-1:0] kpp_c;
  logic signed [W-1:0] kxe_sh;
  logic signed [W-1:0] kpp_sh;
  logic signed [W-1:0] x_new;
  logic signed [W-1:0] p_new;
  logic                div_start;
  logic                div_done;
  logic [W-1:0]        div_quot;
  logic                div_zero;

  assign in_ready  = rst_n && (state_q == StIdle) && !cfg_we;
  assign accept    = in_valid && in_ready;
  assign ch_ok     = 32'(in_ch) < NCH;
  assign cfg_hit   = cfg_we && (state_q == StIdle) && (32'(cfg_ch) < NCH);
  assign div_start = (state_q == StPred);
  assign x_cur     = x_q[ch_q];
  assign k_s       = div_quot;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept && ch_ok) state_d = StPred;
      StPred:  state_d = StDiv;
      StDiv:   if (div_done) state_d = StUpd;
      StUpd:   state_d = StOut;
      StOut:   if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    kxe_c = '0;
    kpp_c = (2 * W)'(k_s) * (2 * W)'(pp_q);
`ifdef KF_SAT_EN
    pp_c   = W'(sat_add(64'(p_q[ch_q]), 64'(q_q[ch_q]), W));
    s_c    = W'(sat_add(64'(pp_c), 64'(r_q[ch_q]), W));
    e_c    = W'(sat_add(64'(z_q), -64'(x_cur), W));
    kxe_c  = (2 * W)'(k_s) * (2 * W)'(e_c);
    kxe_sh = W'(sat_clip(64'(kxe_c >>> FRAC), W));
    kpp_sh = W'(sat_clip(64'(kpp_c >>> FRAC), W));
    x_new  = W'(sat_add(64'(x_cur), 64'(kxe_sh), W));
`else
    pp_c   = p_q[ch_q] + q_q[ch_q];
    s_c    = pp_c + r_q[ch_q];
    e_c    = z_q - x_cur;
    kxe_c  = (2 * W)'(k_s) * (2 * W)'(e_c);
    kxe_sh = W'(kxe_c >>> FRAC);
    kpp_sh = W'(kpp_c >>> FRAC);
    x_new  = x_cur + kxe_sh;
`endif
    p_new = pp_q - kpp_sh;
  end

  kf_div_seq #(
    .W    (W),
    .FRAC (FRAC)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .start (div_start),
    .num   (pp_c),
    .den   (s_c),
    .done  (div_done),
    .quot  (div_quot),
    .div0  (div_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ch_q       <= '0;
      z_q        <= '0;
      pp_q       <= '0;
      out_ch_q   <= '0;
      out_x_q    <= '0;
      out_p_q    <= '0;
      out_div0_q <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        x_q[i] <= W'(RstX);
        p_q[i] <= One;
        q_q[i] <= W'(RstQ);
        r_q[i] <= One;
      end
    end else begin
      state_q <= state_d;
      if (accept) begin
        ch_q <= in_ch;
        z_q  <= in_z;
      end
      if (state_q == StPred) pp_q <= pp_c;
      if (cfg_hit) begin
        unique case (cfg_sel)
          CfgX: x_q[cfg_ch] <= cfg_wdata;
          CfgP: p_q[cfg_ch] <= cfg_wdata;
          CfgQ: q_q[cfg_ch] <= cfg_wdata;
          CfgR: r_q[cfg_ch] <= cfg_wdata;
          default: ;
        endcase
      end
      if (state_q == StUpd) begin
        x_q[ch_q]  <= x_new;
        p_q[ch_q]  <= p_new;
        out_ch_q   <= ch_q;
        out_x_q    <= x_new;
        out_p_q    <= p_new;
        out_div0_q <= div_zero;
      end
    end
  end

  assign out_valid = (state_q == StOut);
  assign out_ch    = out_ch_q;
  assign out_x     = out_x_q;
  assign out_p     = out_p_q;
  assign out_div0  = out_div0_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_kf_scalar_mc.sv
// Scoreboard bench for kf_scalar_mc: directed samples with hand-computed results.
module tb_kf_scalar_mc;

  localparam int W   = 24;
  localparam int Lat = W + 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_ch;
  logic [W-1:0] in_z;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   out_ch;
  logic [W-1:0] out_x;
  logic [W-1:0] out_p;
  logic         out_div0;
  logic         cfg_we;
  logic [1:0]   cfg_sel;
  logic [1:0]   cfg_ch;
  logic [W-1:0] cfg_wdata;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic seen = 1'b0;

  typedef struct {
    logic [1:0]          ch;
    logic signed [W-1:0] x;
    logic signed [W-1:0] p;
    logic                div0;
    int                  acc;
  } exp_t;

  exp_t sb[$];

  kf_scalar_mc #(
    .W    (24),
    .FRAC (14),
    .NCH  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ch     (in_ch),
    .in_z      (in_z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_x     (out_x),
    .out_p     (out_p),
    .out_div0  (out_div0),
    .cfg_we    (cfg_we),
    .cfg_sel   (cfg_sel),
    .cfg_ch    (cfg_ch),
    .cfg_wdata (cfg_wdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  // Monitor: compare each result once, on its first out_valid cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && !seen) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got ch=%0d x=%0d, want no output", out_ch,
                 $signed(out_x));
      end else begin
        e = sb.pop_front();
        chk("out_ch", out_ch, e.ch);
        chk("out_x", $signed(out_x), e.x);
        chk("out_p", $signed(out_p), e.p);
        chk("out_div0", out_div0, e.div0);
        chk("latency", cyc - e.acc, Lat);
      end
    end
    seen = rst_n && out_valid;
  end

  task automatic cfg(input logic [1:0] sel, input logic [1:0] ch, input logic signed [W-1:0] d);
    cfg_we = 1'b1;
    cfg_sel = sel;
    cfg_ch = ch;
    cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic send(input logic [1:0] ch, input logic signed [W-1:0] z, input bit push,
                      input logic signed [W-1:0] ex, input logic signed [W-1:0] ep,
                      input logic ed);
    exp_t e;
    int n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", in_ready, 1);
    in_valid = 1'b1;
    in_ch = ch;
    in_z = z;
    @(negedge clk);
    in_valid = 1'b0;
    chk("accept_busy", busy, 1);
    if (push) begin
      e.ch = ch;
      e.x = ex;
      e.p = ep;
      e.div0 = ed;
      e.acc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", sb.size(), 0);
    chk("drain_busy", busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  initial begin
    logic signed [W-1:0] hx;
    logic signed [W-1:0] hp;
    int n;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_ch = '0;
    in_z = '0;
    out_ready = 1'b1;
    cfg_we = 1'b0;
    cfg_sel = '0;
    cfg_ch = '0;
    cfg_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_x", out_x, 0);
    chk("rst_out_p", out_p, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_out_div0", out_div0, 0);
    chk("idle_in_ready", in_ready, 1);

    // Basic update from reset context on ch0
    send(2'd0, 32768, 1'b1, 16384, 8192, 1'b0);
    drain();

    // Divide-by-zero on ch1
    cfg(CFG_P(), 2'd1, 0);
    cfg(2'b10, 2'd1, 0);
    cfg(2'b11, 2'd1, 0);
    cfg(2'b00, 2'd1, 100);
    send(2'd1, 5000, 1'b1, 100, 0, 1'b1);
    drain();

    // Backpressure: ch0 now x=16384 P=8192
    out_ready = 1'b0;
    send(2'd0, 16384, 1'b1, 16384, 5462, 1'b0);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid", out_valid, 1);
    hx = out_x;
    hp = out_p;
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_x", $signed(out_x), hx);
      chk("bp_hold_p", $signed(out_p), hp);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_busy", busy, 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_after_valid", out_valid, 0);
    chk("bp_after_busy", busy, 0);

    // Channel isolation
    send(2'd2, -16384, 1'b1, -8192, 8192, 1'b0);
    drain();
    send(2'd3, 32768, 1'b1, 16384, 8192, 1'b0);
    drain();
    send(2'd1, 5000, 1'b1, 100, 0, 1'b1);
    drain();
    send(2'd0, 16384, 1'b1, 16384, 4097, 1'b0);
    drain();

    // Config/sample collision: config wins, sample dropped
    cfg_we = 1'b1;
    cfg_sel = 2'b00;
    cfg_ch = 2'd3;
    cfg_wdata = 500;
    in_valid = 1'b1;
    in_ch = 2'd3;
    in_z = 999;
    #1;
    chk("collide_in_ready", in_ready, 0);
    @(negedge clk);
    cfg_we = 1'b0;
    in_valid = 1'b0;
    chk("collide_not_accepted", busy, 0);
    send(2'd3, 500, 1'b1, 500, 5462, 1'b0);
    drain();

    // Reset mid-divide aborts the sample and restores defaults
    send(2'd0, 777, 1'b0, 0, 0, 1'b0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_busy", busy, 0);
    chk("midrst_out_valid", out_valid, 0);
    repeat (40) @(negedge clk);
    send(2'd0, 32768, 1'b1, 16384, 8192, 1'b0);
    drain();

    // Overflow corner on ch2
    cfg(2'b00, 2'd2, 8388000);
    cfg(2'b11, 2'd2, 0);
`ifdef KF_SAT_EN
    send(2'd2, -8388608, 1'b1, -608, 0, 1'b0);
`else
    send(2'd2, -8388608, 1'b1, -8388608, 0, 1'b0);
`endif
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  function automatic logic [1:0] CFG_P();
    return 2'b01;
  endfunction

endmodule
